// File: rtl/bru_pkg.sv
// Shared encodings for the branch resolve unit: decode bits, branch codes, flag indices, RAS ops.
package bru_pkg;

  localparam int DEC_JALR   = 0;
  localparam int DEC_JAL    = 2;
  localparam int DEC_BRANCH = 3;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_LTU  = 1;
  localparam int FLAG_LT   = 2;

  typedef enum logic [1:0] {NONE, PUSH, POP, POP_PUSH} ras_op_e;

  function automatic logic is_link_reg(input logic [4:0] addr);
    return (addr == 5'd1) || (addr == 5'd5);
  endfunction

endpackage

// File: rtl/bru_ras.sv
// Circular return-address stack; push-when-full evicts the oldest entry, pop-when-empty is ignored.
// Top/valid are registered and show the post-update state one cycle after the op.
module bru_ras
  import bru_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  ras_op_e         op,
  input  logic [XLEN-1:0] push_pc,
  output logic [XLEN-1:0] top_pc,
  output logic            top_valid,
  output logic            overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr, ptr_n, wr_idx;
  logic [PW:0]     cnt, cnt_n;
  logic            wr;

  // ptr addresses the next free slot; the top lives at ptr-1.
  always_comb begin
    ptr_n    = ptr;
    cnt_n    = cnt;
    wr       = 1'b0;
    wr_idx   = ptr;
    overflow = 1'b0;
    case (op)
      PUSH: begin
        wr       = 1'b1;
        ptr_n    = ptr + 1'b1;
        overflow = (cnt == FULL);
        if (cnt != FULL) cnt_n = cnt + 1'b1;
      end
      POP: begin
        if (cnt != '0) begin
          ptr_n = ptr - 1'b1;
          cnt_n = cnt - 1'b1;
        end
      end
      POP_PUSH: begin
        wr = 1'b1;
        if (cnt != '0) begin
          wr_idx = ptr - 1'b1;
        end else begin
          ptr_n = ptr + 1'b1;
          cnt_n = (PW+1)'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_idx] <= push_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      top_pc    <= '0;
      top_valid <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      top_valid <= (cnt_n != '0);
      if (cnt_n == '0) top_pc <= '0;
      else if (wr)     top_pc <= push_pc;
      else             top_pc <= mem[ptr_n - 1'b1];
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch/jump resolution with registered redirect, BTB update and RAS; results one cycle after accept.
// Stall/kill suppress all effects. Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             stall,
  input  logic             kill,
  input  logic             pred_valid,
  input  logic             predicted_taken,
  input  logic [XLEN-1:0]  predicted_pc,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  immediate,
  input  logic [XLEN-1:0]  op1,
  input  logic [2:0]       func3,
  input  logic [2:0]       alu_flags,
  input  logic [8:0]       decoded_instruction,
  input  logic [4:0]       rd_addr,
  input  logic [4:0]       rs1_addr,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             btb_update,
  output logic [XLEN-1:0]  btb_update_pc,
  output logic [XLEN-1:0]  btb_update_target,
  output logic             btb_update_taken,
  output logic [XLEN-1:0]  ras_top_pc,
  output logic             ras_top_valid,
  output logic [CNT_W-1:0] perf_branch_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt,
  output logic [CNT_W-1:0] perf_ras_ovf_cnt
);

  logic            is_jalr, is_jal, is_br, is_jump, accept, resolve;
  logic            cond, taken, mispred, call, ret, ras_ovf;
  logic [XLEN-1:0] sum, target, seq_pc;
  ras_op_e         ras_op;

  assign is_jalr = decoded_instruction[DEC_JALR];
  assign is_jal  = decoded_instruction[DEC_JAL];
  assign is_br   = decoded_instruction[DEC_BRANCH];
  assign is_jump = is_jal | is_jalr;
  assign accept  = valid & ~stall & ~kill;
  assign resolve = accept & (is_br | is_jump);

  assign sum    = (is_jalr ? op1 : pc) + immediate;
  assign target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign seq_pc = pc + XLEN'(4);

  always_comb begin
    case (func3)
      F3_BEQ:  cond = alu_flags[FLAG_ZERO];
      F3_BNE:  cond = ~alu_flags[FLAG_ZERO];
      F3_BLT:  cond = alu_flags[FLAG_LT];
      F3_BGE:  cond = ~alu_flags[FLAG_LT];
      F3_BLTU: cond = alu_flags[FLAG_LTU];
      F3_BGEU: cond = ~alu_flags[FLAG_LTU];
      default: cond = 1'b0;
    endcase
  end

  assign taken = is_jump | (is_br & cond);

  always_comb begin
    mispred = 1'b0;
    if (!pred_valid)  mispred = taken;
    else if (is_jump) mispred = ~predicted_taken | (target != predicted_pc);
    else if (is_br)   mispred = (cond ^ predicted_taken) | (cond & (target != predicted_pc));
  end

  // Call+return with distinct link regs replaces the top rather than growing the stack.
  assign call = is_jump & is_link_reg(rd_addr);
  assign ret  = is_jalr & is_link_reg(rs1_addr);

  always_comb begin
    ras_op = NONE;
    if (accept) begin
      if (call && ret) ras_op = (rd_addr == rs1_addr) ? PUSH : POP_PUSH;
      else if (call)   ras_op = PUSH;
      else if (ret)    ras_op = POP;
    end
  end

  bru_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (ras_op),
    .push_pc   (seq_pc),
    .top_pc    (ras_top_pc),
    .top_valid (ras_top_valid),
    .overflow  (ras_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      btb_update        <= 1'b0;
      btb_update_pc     <= '0;
      btb_update_target <= '0;
      btb_update_taken  <= 1'b0;
    end else begin
      redirect_valid <= resolve & mispred;
      btb_update     <= resolve;
      if (resolve) begin
        redirect_pc       <= taken ? target : seq_pc;
        btb_update_pc     <= pc;
        btb_update_target <= target;
        btb_update_taken  <= taken;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt, mis_cnt, ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (resolve)           br_cnt  <= br_cnt + 1'b1;
      if (resolve & mispred) mis_cnt <= mis_cnt + 1'b1;
      if (ras_ovf)           ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign perf_branch_cnt  = br_cnt;
  assign perf_mispred_cnt = mis_cnt;
  assign perf_ras_ovf_cnt = ovf_cnt;
`else
  assign perf_branch_cnt  = '0;
  assign perf_mispred_cnt = '0;
  assign perf_ras_ovf_cnt = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{decoded_instruction[8:4], decoded_instruction[1], ras_ovf};

endmodule
